// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter and store-merge logic.
package ram_arbiter_pkg;

  localparam int BYTES     = 4;
  localparam int ADDR_BITS = 16;

  typedef logic [8*BYTES-1:0]   Word;
  typedef logic [ADDR_BITS-1:0] RamAddress;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MemSize;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } ArbState;

  // Word-aligned form of a byte address.
  function automatic RamAddress WORD_ADDRESS(input RamAddress a);
    return {a[ADDR_BITS-1:2], 2'b00};
  endfunction

  // Size 3 is reserved and is always rejected as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_store_merge.sv
// Combinational merge of sub-word store data into an existing word.
// Data is right-justified; lane selects the target byte (or half via lane[1]).
module ram_arbiter_store_merge
  import ram_arbiter_pkg::*;
(
  input  Word        old_word,
  input  Word        wdata,
  input  MemSize     size,
  input  logic [1:0] lane,
  output Word        merged
);

  // Replace only the addressed lane(s); a word size passes wdata through.
  always_comb begin
    merged = old_word;
    case (size)
      BYTE:    merged[{lane, 3'b000} +: 8]         = wdata[7:0];
      HALF:    merged[{lane[1], 4'b0000} +: 16]    = wdata[15:0];
      default: merged                              = wdata;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data-RAM arbiter: D (load/store) beats I (fetch), sub-word
// stores become a two-cycle read-modify-write.
// Optional macro RAM_ARBITER_STATS_EN adds stall / RMW counters and dump_stats.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [15:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_misaligned,
  output logic              ram_we,
  output logic [15:0]       ram_address,
  output logic [31:0]       ram_in,
  input  logic [31:0]       ram_out
);

  ArbState state;
  Word     merge_q;
  Word     merged;
  logic    rmw_start;
  logic    d_bad;

  assign d_bad   = is_misaligned(d_size, d_addr[1:0]);
  assign i_data  = ram_out;
  assign d_rdata = ram_out;

  ram_arbiter_store_merge u_merge (
    .old_word (ram_out),
    .wdata    (d_wdata),
    .size     (MemSize'(d_size)),
    .lane     (d_addr[1:0]),
    .merged   (merged)
  );

  // Per-cycle RAM port steering; D always wins, I only gets idle cycles.
  always_comb begin
    ram_we       = 1'b0;
    ram_address  = i_addr;
    ram_in       = d_wdata;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    d_misaligned = 1'b0;
    rmw_start    = 1'b0;
    if (reset) begin
      // everything held quiet; a pending RMW write is dropped
    end else if (state == RMW_WR) begin
      ram_address = d_addr;
      ram_we      = 1'b1;
      ram_in      = merge_q;
      d_ready     = 1'b1;
    end else if (d_req && !d_bad) begin
      ram_address = d_addr;
      if (!d_we) begin
        d_ready = 1'b1;
      end else if (d_size == WORD) begin
        ram_we  = 1'b1;
        d_ready = 1'b1;
      end else begin
        rmw_start = 1'b1;
      end
    end else begin
      // Rejected D never touches the RAM, so a fetch can share the cycle.
      if (d_req) begin
        d_ready      = 1'b1;
        d_misaligned = 1'b1;
      end
      i_ready = i_req;
    end
  end

  // State and merge register: RMW read cycle captures the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      merge_q <= '0;
    end else if (rmw_start) begin
      state   <= RMW_WR;
      merge_q <= merged;
    end else begin
      state   <= IDLE;
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  logic [STALL_CNT_WIDTH-1:0] i_stall_cnt;
  logic [STALL_CNT_WIDTH-1:0] rmw_cnt;

  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_stall_cnt <= '0;
      rmw_cnt     <= '0;
    end else begin
      if (i_req && !i_ready && !(&i_stall_cnt)) i_stall_cnt <= i_stall_cnt + 1'b1;
      if (rmw_start && !(&rmw_cnt))             rmw_cnt     <= rmw_cnt + 1'b1;
    end
  end

  task automatic dump_stats;
    $display("ram_arbiter stats: i_stall_cnt=%0d rmw_cnt=%0d", i_stall_cnt, rmw_cnt);
  endtask
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural word RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misaligned;
  logic        ram_we;
  logic [15:0] ram_address;
  logic [31:0] ram_in;
  logic [31:0] ram_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  always #5 clk = ~clk;

  assign ram_out = mem[ram_address[9:2]];
  always @(posedge clk) if (ram_we) mem[ram_address[9:2]] <= ram_in;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .d_misaligned(d_misaligned),
    .ram_we(ram_we), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
  );

  task automatic idle_in;
    i_req = 0; i_addr = 16'h0; d_req = 0; d_we = 0; d_size = 2'd2;
    d_addr = 16'h0; d_wdata = 32'h0;
  endtask

  // advance from the check point (negedge) to just past the next posedge
  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] v);
    idle_in();
    d_req = 1; d_we = 1; d_size = 2'd2; d_addr = a; d_wdata = v;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || ram_we !== 1'b1) begin
      errors++; $display("FAIL preload_%h: d_ready=%b ram_we=%b want 1 1", a, d_ready, ram_we);
    end
    next_cycle();
    idle_in();
  endtask

  task automatic test_reset;
    reset = 1;
    i_req = 1; i_addr = 16'h50;
    d_req = 1; d_we = 1; d_size = 2'd2; d_addr = 16'h50; d_wdata = 32'h12345678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0 || ram_we !== 1'b0 || d_misaligned !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs c%0d: i_ready=%b d_ready=%b ram_we=%b mis=%b want 0 0 0 0",
                 c, i_ready, d_ready, ram_we, d_misaligned);
      end
      next_cycle();
    end
    reset = 0;
    idle_in();
    checks++;
    if (mem[8'h14] !== 32'h0) begin
      errors++; $display("FAIL reset_ram: mem[0x50]=%h want 00000000", mem[8'h14]);
    end
  endtask

  task automatic test_fetch;
    preload(16'h10, 32'h11223344);
    i_req = 1; i_addr = 16'h10;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1 || i_data !== 32'h11223344 || d_ready !== 1'b0) begin
      errors++; $display("FAIL fetch: i_ready=%b i_data=%h d_ready=%b want 1 11223344 0",
                         i_ready, i_data, d_ready);
    end
    next_cycle();
    idle_in();
  endtask

  task automatic test_word_store;
    i_req = 1; i_addr = 16'h20;
    d_req = 1; d_we = 1; d_size = 2'd2; d_addr = 16'h20; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || ram_we !== 1'b1 || ram_in !== 32'hDEADBEEF ||
        d_misaligned !== 1'b0) begin
      errors++; $display("FAIL word_store: d_ready=%b i_ready=%b ram_we=%b ram_in=%h mis=%b want 1 0 1 deadbeef 0",
                         d_ready, i_ready, ram_we, ram_in, d_misaligned);
    end
    next_cycle();
    d_req = 0;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1 || i_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_store_fetch: i_ready=%b i_data=%h want 1 deadbeef", i_ready, i_data);
    end
    next_cycle();
    idle_in();
  endtask

  // Two-cycle sub-word store with a fetch pending throughout.
  task automatic rmw_store(input logic [1:0] sz, input logic [15:0] a, input logic [31:0] wd,
                           input logic [31:0] exp);
    i_req = 1; i_addr = 16'h10;
    d_req = 1; d_we = 1; d_size = sz; d_addr = a; d_wdata = wd;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b0 || i_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rmw_c1_%h: d_ready=%b i_ready=%b ram_we=%b want 0 0 0", a, d_ready, i_ready, ram_we);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0 || ram_we !== 1'b1 || ram_in !== exp ||
        ram_address !== a) begin
      errors++; $display("FAIL rmw_c2_%h: d_ready=%b i_ready=%b ram_we=%b ram_in=%h addr=%h want 1 0 1 %h %h",
                         a, d_ready, i_ready, ram_we, ram_in, ram_address, exp, a);
    end
    next_cycle();
    checks++;
    if (mem[a[9:2]] !== exp) begin
      errors++; $display("FAIL rmw_ram_%h: mem=%h want %h", a, mem[a[9:2]], exp);
    end
  endtask

  task automatic test_rmw;
    preload(16'h30, 32'h11223344);
    rmw_store(2'd0, 16'h31, 32'h000000AB, 32'h1122AB44);
    rmw_store(2'd1, 16'h32, 32'h0000BEEF, 32'hBEEFAB44);  // back-to-back with the byte store
    idle_in();
    d_req = 1; d_we = 0; d_size = 2'd2; d_addr = 16'h30;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b1 || d_rdata !== 32'hBEEFAB44 || ram_we !== 1'b0) begin
      errors++; $display("FAIL load_after_rmw: d_ready=%b d_rdata=%h ram_we=%b want 1 beefab44 0",
                         d_ready, d_rdata, ram_we);
    end
    next_cycle();
    idle_in();
  endtask

  task automatic test_misaligned;
    logic        we_t [3]   = '{1'b1, 1'b0, 1'b1};
    logic [1:0]  sz_t [3]   = '{2'd1, 2'd2, 2'd3};
    logic [15:0] ad_t [3]   = '{16'h33, 16'h22, 16'h20};
    logic [15:0] chk_t [3]  = '{16'h30, 16'h20, 16'h20};
    logic [31:0] val_t [3]  = '{32'hBEEFAB44, 32'hDEADBEEF, 32'hDEADBEEF};
    for (int k = 0; k < 3; k++) begin
      i_req = 1; i_addr = 16'h10;
      d_req = 1; d_we = we_t[k]; d_size = sz_t[k]; d_addr = ad_t[k]; d_wdata = 32'h0;
      @(negedge clk);
      checks++;
      if (d_ready !== 1'b1 || d_misaligned !== 1'b1 || ram_we !== 1'b0 ||
          i_ready !== 1'b1 || i_data !== 32'h11223344) begin
        errors++; $display("FAIL misaligned_%0d: d_ready=%b mis=%b ram_we=%b i_ready=%b i_data=%h want 1 1 0 1 11223344",
                           k, d_ready, d_misaligned, ram_we, i_ready, i_data);
      end
      next_cycle();
      checks++;
      if (mem[chk_t[k][9:2]] !== val_t[k]) begin
        errors++; $display("FAIL misaligned_ram_%0d: mem=%h want %h", k, mem[chk_t[k][9:2]], val_t[k]);
      end
    end
    idle_in();
  endtask

  task automatic test_reset_rmw;
    preload(16'h40, 32'h0);
    d_req = 1; d_we = 1; d_size = 2'd0; d_addr = 16'h40; d_wdata = 32'hFF;
    @(negedge clk);
    checks++;
    if (d_ready !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_c1: d_ready=%b want 0", d_ready);
    end
    next_cycle();
    reset = 1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || d_ready !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_drop: ram_we=%b d_ready=%b want 0 0", ram_we, d_ready);
    end
    next_cycle();
    reset = 0;
    idle_in();
`ifdef RAM_ARBITER_STATS_EN
    checks++;
    if (dut.rmw_cnt !== '0) begin
      errors++; $display("FAIL rst_rmw_cnt: rmw_cnt=%0d want 0", dut.rmw_cnt);
    end
`endif
    i_req = 1; i_addr = 16'h10;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1 || i_data !== 32'h11223344 || ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_rmw_fetch: i_ready=%b i_data=%h ram_we=%b want 1 11223344 0",
                         i_ready, i_data, ram_we);
    end
    checks++;
    if (mem[8'h10] !== 32'h0) begin
      errors++; $display("FAIL rst_rmw_ram: mem[0x40]=%h want 00000000", mem[8'h10]);
    end
    next_cycle();
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1;
    #1;
    test_reset();
    test_fetch();
    test_word_store();
    test_rmw();
    test_misaligned();
    test_reset_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
